// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing analyser: measures line/frame geometry from an
// h_sync/v_sync/de stream, recovers active-area coordinates and tracks lock.
module vga_timing_detector #(
    parameter int W           = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_en,
    input  logic         h_sync,
    input  logic         v_sync,
    input  logic         de,
    output logic         de_o,
    output logic [W-1:0] x_pos,
    output logic [W-1:0] y_pos,
    output logic [W-1:0] h_total,
    output logic [W-1:0] h_sync_w,
    output logic [W-1:0] h_active,
    output logic [W-1:0] v_total,
    output logic [W-1:0] v_active,
    output logic         locked,
    output logic         frame_start,
    output logic         err
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        S_UNLOCKED,
        S_MEASURE,
        S_CHECK,
        S_LOCKED
    } state_t;

    typedef struct packed {
        logic [W-1:0] h_total;
        logic [W-1:0] h_active;
        logic [W-1:0] v_total;
        logic [W-1:0] v_active;
    } geom_t;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == MAX) ? v : v + ONE;
    endfunction

    // Previous sample; edges compare it against the live inputs at each pix_en edge.
    logic         s_hs, s_vs, s_de;
    logic [W-1:0] line_cnt, hs_low_cnt, de_cnt, line_num, v_act_cnt, line_ref;
    logic         line_had_de, first_line, line_bad;
    geom_t        ref_geom, geom_new;
    state_t       state, state_next;
    logic [7:0]   match_cnt, match_next;
    logic         ref_load, err_next;

    logic h_fall, h_rise, v_fall, de_fall, timeout;
    logic line_bad_now, frame_ok;
    logic [W-1:0] v_act_next;

    assign h_fall  = pix_en &  s_hs & ~h_sync;
    assign h_rise  = pix_en & ~s_hs &  h_sync;
    assign v_fall  = pix_en &  s_vs & ~v_sync;
    assign de_fall = pix_en &  s_de & ~de;
    assign timeout = pix_en & ~h_fall & (line_cnt == MAX - ONE);

    assign line_bad_now = h_fall & ~first_line & (line_cnt != line_ref);
    assign v_act_next   = (h_fall && line_had_de) ? sat_inc(v_act_cnt) : v_act_cnt;

    // Geometry as it stands after this edge; a coincident line edge is folded in first.
    always_comb begin
        geom_new.h_total  = h_fall ? line_cnt : h_total;
        geom_new.h_active = h_fall ? de_cnt   : h_active;
        geom_new.v_total  = h_fall ? sat_inc(line_num) : line_num;
        geom_new.v_active = v_act_next;
    end

    assign frame_ok = (geom_new == ref_geom) && !line_bad && !line_bad_now;
    assign locked   = (state == S_LOCKED);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        match_next = match_cnt;
        ref_load   = 1'b0;
        err_next   = 1'b0;
        if (timeout) begin
            state_next = S_UNLOCKED;
            match_next = '0;
            err_next   = (state == S_LOCKED);
        end else if (v_fall) begin
            case (state)
                S_UNLOCKED: state_next = S_MEASURE;
                S_MEASURE: begin
                    ref_load   = 1'b1;
                    match_next = 8'd1;
                    state_next = (LOCK_FRAMES <= 1) ? S_LOCKED : S_CHECK;
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        match_next = match_cnt + 8'd1;
                        if (match_cnt + 8'd1 >= 8'(LOCK_FRAMES)) state_next = S_LOCKED;
                    end else begin
                        ref_load   = 1'b1;
                        match_next = 8'd1;
                    end
                end
                S_LOCKED: begin
                    if (!frame_ok) begin
                        err_next   = 1'b1;
                        ref_load   = 1'b1;
                        match_next = 8'd1;
                        state_next = S_CHECK;
                    end
                end
                default: state_next = S_UNLOCKED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_UNLOCKED;
            match_cnt   <= '0;
            ref_geom    <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            match_cnt   <= match_next;
            frame_start <= v_fall;
            err         <= err_next;
            if (ref_load) ref_geom <= geom_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_hs        <= 1'b1;
            s_vs        <= 1'b1;
            s_de        <= 1'b0;
            de_o        <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            h_total     <= '0;
            h_sync_w    <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            line_cnt    <= '0;
            hs_low_cnt  <= '0;
            de_cnt      <= '0;
            line_num    <= '0;
            v_act_cnt   <= '0;
            line_ref    <= '0;
            line_had_de <= 1'b0;
            first_line  <= 1'b1;
            line_bad    <= 1'b0;
        end else if (pix_en) begin
            s_hs  <= h_sync;
            s_vs  <= v_sync;
            s_de  <= de;
            de_o  <= de;
            x_pos <= (de && s_de) ? sat_inc(x_pos) : '0;

            if (v_fall)       y_pos <= '0;
            else if (de_fall) y_pos <= sat_inc(y_pos);

            if (h_fall) begin
                line_cnt    <= ONE;
                h_total     <= line_cnt;
                h_active    <= de_cnt;
                de_cnt      <= de ? ONE : '0;
                line_had_de <= de;
                hs_low_cnt  <= ONE;
            end else begin
                line_cnt    <= sat_inc(line_cnt);
                line_had_de <= line_had_de | de;
                if (de)      de_cnt     <= sat_inc(de_cnt);
                if (!h_sync) hs_low_cnt <= sat_inc(hs_low_cnt);
            end

            if (h_rise) h_sync_w <= hs_low_cnt;

            if (v_fall) begin
                v_total    <= geom_new.v_total;
                v_active   <= geom_new.v_active;
                line_num   <= '0;
                v_act_cnt  <= '0;
                first_line <= 1'b1;
                line_bad   <= 1'b0;
            end else if (h_fall) begin
                line_num  <= sat_inc(line_num);
                v_act_cnt <= v_act_next;
                if (first_line) begin
                    line_ref   <= line_cnt;
                    first_line <= 1'b0;
                end else if (line_bad_now) begin
                    line_bad <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Scoreboarded bench for vga_timing_detector on a reduced 40x12 raster
// (sync 30..35, DE h<24 & v<8, v_sync low lines 9..10), pix_en every 4th clk.
module tb_vga_timing_detector;

    localparam int W       = 10;
    localparam int HT      = 40;
    localparam int HS0     = 30;
    localparam int HS1     = 36;
    localparam int HA      = 24;
    localparam int VT      = 12;
    localparam int VS0     = 9;
    localparam int VS1     = 11;
    localparam int VA      = 8;
    localparam int PIX_DIV = 4;

    logic         clk = 1'b0;
    logic         reset, pix_en, h_sync, v_sync, de;
    logic         de_o, locked, frame_start, err;
    logic [W-1:0] x_pos, y_pos, h_total, h_sync_w, h_active, v_total, v_active;

    always #5 clk = ~clk;

    vga_timing_detector #(.W(W), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .de_o(de_o), .x_pos(x_pos), .y_pos(y_pos),
        .h_total(h_total), .h_sync_w(h_sync_w), .h_active(h_active),
        .v_total(v_total), .v_active(v_active),
        .locked(locked), .frame_start(frame_start), .err(err)
    );

    typedef struct {
        int de;
        int x;
        int y;
        bit chk_y;
        int fs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   err_count = 0;
    bit   pix_seen = 1'b0;
    bit   prev_vs = 1'b1;
    bit   y_valid = 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) pix_seen <= pix_en;

    // Output monitor: pops one expectation per pix_en edge; pulses must be low otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (err) err_count++;
            if (pix_seen) begin
                check("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("de_o", int'(de_o), e.de);
                    check("x_pos", int'(x_pos), e.x);
                    check("frame_start", int'(frame_start), e.fs);
                    if (e.chk_y) check("y_pos", int'(y_pos), e.y);
                end
            end else begin
                check("pulse_idle", int'({frame_start, err}), 0);
            end
        end
    end

    task automatic send(input bit hs, input bit vs, input bit d, input int h, input int v);
        exp_t e;
        h_sync = hs;
        v_sync = vs;
        de     = d;
        pix_en = 1'b1;
        e.de    = int'(d);
        e.x     = d ? h : 0;
        e.y     = v;
        e.fs    = int'(prev_vs && !vs);
        if (prev_vs && !vs) y_valid = 1'b1;
        e.chk_y = d && y_valid;
        prev_vs = vs;
        sb.push_back(e);
        @(negedge clk);
        pix_en = 1'b0;
        repeat (PIX_DIV - 1) @(negedge clk);
    endtask

    // Raster samples with linear index first..last; long_line gets one extra blank sample.
    task automatic gen(input int first, input int last, input int long_line);
        int idx;
        idx = 0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < ((v == long_line) ? HT + 1 : HT); h++) begin
                if (idx >= first && idx <= last)
                    send(!(h >= HS0 && h < HS1), !(v >= VS0 && v < VS1),
                         (h < HA && v < VA), h, v);
                idx++;
            end
        end
    endtask

    task automatic frame(input int long_line);
        gen(0, 100000, long_line);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_x"}, int'(x_pos), 0);
        check({tag, "_y"}, int'(y_pos), 0);
        check({tag, "_htot"}, int'(h_total), 0);
        check({tag, "_hsw"}, int'(h_sync_w), 0);
        check({tag, "_hact"}, int'(h_active), 0);
        check({tag, "_vtot"}, int'(v_total), 0);
        check({tag, "_vact"}, int'(v_active), 0);
        check({tag, "_bits"}, int'({de_o, locked, frame_start, err}), 0);
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        h_sync = 1'b1;
        v_sync = 1'b1;
        de     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst0");
        reset = 1'b0;

        frame(-1); check("lock_f0", int'(locked), 0);
        frame(-1); check("lock_f1", int'(locked), 0);
        frame(-1); check("lock_f2", int'(locked), 1);
        check("err_f2", err_count, 0);

        // Clean frame with a 100-clk pix_en stall mid-line, then a geometry probe.
        gen(0, 2 * HT + 10, -1);
        repeat (100) @(negedge clk);
        gen(2 * HT + 11, 5 * HT + 35, -1);
        check("h_total", int'(h_total), HT);
        check("h_sync_w", int'(h_sync_w), HS1 - HS0);
        check("h_active", int'(h_active), HA);
        check("v_total", int'(v_total), VT);
        check("v_active", int'(v_active), VA);
        check("lock_f3", int'(locked), 1);
        gen(5 * HT + 36, 100000, -1);

        // One long line while locked.
        frame(3);
        check("err_long", err_count, 1);
        check("lock_long", int'(locked), 0);
        frame(-1);
        frame(-1);
        check("relock_long", int'(locked), 1);
        check("err_relock", err_count, 1);

        // Signal loss: syncs stuck high long enough for the line counter to saturate.
        repeat (1100) send(1'b1, 1'b1, 1'b0, 0, 0);
        check("err_timeout", err_count, 2);
        check("lock_timeout", int'(locked), 0);
        frame(-1); check("lock_to_f0", int'(locked), 0);
        frame(-1); check("lock_to_f1", int'(locked), 0);
        frame(-1); check("lock_to_f2", int'(locked), 1);

        // Asynchronous reset mid-frame, then a full relock sequence.
        gen(0, 4 * HT + 36, -1);
        #2 reset = 1'b1;
        #1 check_reset_outs("rst_mid");
        @(negedge clk);
        reset   = 1'b0;
        prev_vs = 1'b1;
        y_valid = 1'b0;
        gen(4 * HT + 37, 100000, -1); check("lock_rs_f0", int'(locked), 0);
        frame(-1);                    check("lock_rs_f1", int'(locked), 0);
        frame(-1);                    check("lock_rs_f2", int'(locked), 1);
        check("err_final", err_count, 2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
